// File: rtl/fetch_unit.sv
// Instruction fetch stage sitting directly in front of the instruction cache.
//
// Owns the program counter and issues one ibus request at a time. Each request
// is held stable until data_ok. The returned word is then buffered and offered
// to decode on a valid/ready handshake. A redirect that arrives while a request
// is outstanding never withdraws that request: the stage waits for its data_ok
// in the discard state, drops the data, and then fetches from the redirect target.
//
// Ports:
//   clk            rising-edge clock
//   reset          asynchronous active-low reset
//   ireq           ibus request {valid, addr[63:0]}
//   iresp          ibus response {addr_ok, data_ok, data[31:0]}; addr_ok is unused
//   redirect_valid later stage requests a new fetch address
//   redirect_pc    new fetch address
//   out_ready      decode accepts the presented instruction
//   out_valid      instruction presented to decode
//   out_pc         PC of the presented instruction
//   out_inst       presented instruction word (0 when misaligned)
//   out_misalign   presented PC was not word aligned; no bus access was made

typedef struct packed {
  logic        valid;
  logic [63:0] addr;
} ibus_req_t;

typedef struct packed {
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] data;
} ibus_resp_t;

module fetch_unit #(
  parameter logic [63:0] RESET_PC = 64'h8000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output ibus_req_t   ireq,
  input  ibus_resp_t  iresp,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [63:0] out_pc,
  output logic [31:0] out_inst,
  output logic        out_misalign
);

  localparam logic [1:0] StReq     = 2'd0;
  localparam logic [1:0] StHold    = 2'd1;
  localparam logic [1:0] StDiscard = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic [63:0] pend_pc_q, pend_pc_d;
  logic [63:0] buf_pc_q, buf_pc_d;
  logic [31:0] buf_inst_q, buf_inst_d;
  logic        buf_mis_q, buf_mis_d;

  logic pc_aligned;
  logic data_ok;
  logic unused_addr_ok;

  assign pc_aligned     = (pc_q[1:0] == 2'b00);
  assign data_ok        = iresp.data_ok;
  // Completion is signalled by data_ok alone.
  assign unused_addr_ok = iresp.addr_ok;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pend_pc_d  = pend_pc_q;
    buf_pc_d   = buf_pc_q;
    buf_inst_d = buf_inst_q;
    buf_mis_d  = buf_mis_q;

    case (state_q)
      StReq: begin
        if (redirect_valid) begin
          if (!pc_aligned || data_ok) begin
            // Nothing outstanding (or it just completed): retarget directly.
            pc_d = redirect_pc;
          end else begin
            // Cache has seen the request; it must run to completion first.
            pend_pc_d = redirect_pc;
            state_d   = StDiscard;
          end
        end else if (!pc_aligned) begin
          buf_pc_d   = pc_q;
          buf_inst_d = 32'h0;
          buf_mis_d  = 1'b1;
          state_d    = StHold;
        end else if (data_ok) begin
          buf_pc_d   = pc_q;
          buf_inst_d = iresp.data;
          buf_mis_d  = 1'b0;
          state_d    = StHold;
        end
      end

      StHold: begin
        if (redirect_valid) begin
          // Squash the buffer; out_ready is ignored this cycle.
          pc_d    = redirect_pc;
          state_d = StReq;
        end else if (out_ready) begin
          pc_d    = buf_pc_q + 64'd4;
          state_d = StReq;
        end
      end

      StDiscard: begin
        if (data_ok) begin
          pc_d    = redirect_valid ? redirect_pc : pend_pc_q;
          state_d = StReq;
        end else if (redirect_valid) begin
          pend_pc_d = redirect_pc;
        end
      end

      default: state_d = StReq;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StReq;
      pc_q       <= RESET_PC;
      pend_pc_q  <= 64'h0;
      buf_pc_q   <= 64'h0;
      buf_inst_q <= 32'h0;
      buf_mis_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pend_pc_q  <= pend_pc_d;
      buf_pc_q   <= buf_pc_d;
      buf_inst_q <= buf_inst_d;
      buf_mis_q  <= buf_mis_d;
    end
  end

  // The request is gated by reset so an in-flight access disappears at once on
  // assertion. DISCARD is only entered from an aligned outstanding request.
  always_comb begin
    ireq.valid = reset & (((state_q == StReq) & pc_aligned) | (state_q == StDiscard));
    ireq.addr  = pc_q;
  end

  assign out_valid    = (state_q == StHold);
  assign out_pc       = buf_pc_q;
  assign out_inst     = buf_inst_q;
  assign out_misalign = buf_mis_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a table of sequential fetches, followed by
// hand-written redirect, misalignment, wrap and asynchronous reset sequences.
// Expected instructions are queued when data_ok is driven, and they are popped
// when the DUT presents out_valid.
module tb_fetch_unit;

  localparam logic [63:0] RstPc = 64'h8000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic [64:0] ireq_w;
  logic [33:0] iresp_w;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        out_ready;
  logic        out_valid;
  logic [63:0] out_pc;
  logic [31:0] out_inst;
  logic        out_misalign;

  logic        ireq_valid;
  logic [63:0] ireq_addr;
  logic        data_ok;
  logic [31:0] data;

  assign ireq_valid = ireq_w[64];
  assign ireq_addr  = ireq_w[63:0];
  assign iresp_w    = {ireq_valid, data_ok, data};

  fetch_unit #(
    .RESET_PC(RstPc)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .ireq          (ireq_w),
    .iresp         (iresp_w),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .out_ready     (out_ready),
    .out_valid     (out_valid),
    .out_pc        (out_pc),
    .out_inst      (out_inst),
    .out_misalign  (out_misalign)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned lat;    // cycles between first ireq.valid and data_ok
    logic [31:0] inst;
    int unsigned stall;  // cycles of out_ready = 0 while holding
    logic [63:0] exp_pc;
  } vec_t;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] inst;
    logic        mis;
  } exp_t;

  exp_t sb_q[$];
  vec_t vecs[4];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic push_exp(input logic [63:0] pc, input logic [31:0] inst, input logic mis);
    exp_t e;
    e.pc   = pc;
    e.inst = inst;
    e.mis  = mis;
    sb_q.push_back(e);
  endtask

  task automatic expect_out();
    exp_t e;
    chk("out_valid", {63'h0, out_valid}, 64'd1);
    if (sb_q.size() == 0) begin
      n_total++;
      $display("FAIL scoreboard_empty: got output pc %h, expected nothing", out_pc);
    end else begin
      e = sb_q.pop_front();
      chk("out_pc", out_pc, e.pc);
      chk("out_inst", {32'h0, out_inst}, {32'h0, e.inst});
      chk("out_misalign", {63'h0, out_misalign}, {63'h0, e.mis});
    end
  endtask

  task automatic fetch_one(input vec_t v);
    int n;
    n = 0;
    while (!ireq_valid && n < 20) begin
      step();
      n++;
    end
    chk("req_valid", {63'h0, ireq_valid}, 64'd1);
    chk("req_addr", ireq_addr, v.exp_pc);
    for (int i = 0; i < int'(v.lat); i++) begin
      step();
      chk("req_hold_addr", ireq_addr, v.exp_pc);
      chk("req_hold_valid", {63'h0, ireq_valid}, 64'd1);
    end
    data_ok   = 1'b1;
    data      = v.inst;
    out_ready = 1'b0;
    push_exp(v.exp_pc, v.inst, 1'b0);
    step();
    data_ok = 1'b0;
    data    = 32'hDEAD_BEEF;
    expect_out();
    chk("hold_no_req", {63'h0, ireq_valid}, 64'd0);
    for (int i = 0; i < int'(v.stall); i++) begin
      step();
      chk("stall_valid", {63'h0, out_valid}, 64'd1);
      chk("stall_pc", out_pc, v.exp_pc);
      chk("stall_inst", {32'h0, out_inst}, {32'h0, v.inst});
      chk("stall_no_req", {63'h0, ireq_valid}, 64'd0);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("one_handshake", {63'h0, out_valid}, 64'd0);
    chk("next_req_valid", {63'h0, ireq_valid}, 64'd1);
    chk("next_req_addr", ireq_addr, v.exp_pc + 64'd4);
  endtask

  initial begin
    vecs[0] = '{lat: 2, inst: 32'h0000_0013, stall: 0, exp_pc: 64'h8000_0000};
    vecs[1] = '{lat: 0, inst: 32'hABCD_0123, stall: 5, exp_pc: 64'h8000_0004};
    vecs[2] = '{lat: 1, inst: 32'h1234_5678, stall: 0, exp_pc: 64'h8000_0008};
    vecs[3] = '{lat: 3, inst: 32'hFFFF_FFFF, stall: 1, exp_pc: 64'h8000_000C};

    reset          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 64'h0;
    out_ready      = 1'b0;
    data_ok        = 1'b0;
    data           = 32'h0;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_valid", {63'h0, ireq_valid}, 64'd0);
    chk("rst_out_valid", {63'h0, out_valid}, 64'd0);
    chk("rst_out_pc", out_pc, 64'h0);
    chk("rst_out_inst", {32'h0, out_inst}, 64'h0);
    chk("rst_out_mis", {63'h0, out_misalign}, 64'd0);
    reset = 1'b1;
    #1;
    chk("first_req_valid", {63'h0, ireq_valid}, 64'd1);
    chk("first_req_addr", ireq_addr, RstPc);

    // Sequential fetches, including backpressure.
    for (int i = 0; i < 4; i++) fetch_one(vecs[i]);

    // Redirect one cycle after the request at ...0010; data_ok 3 cycles later.
    step();
    chk("rd1_req_addr", ireq_addr, 64'h8000_0010);
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_0100;
    step();
    redirect_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk("discard_addr", ireq_addr, 64'h8000_0010);
      chk("discard_valid", {63'h0, ireq_valid}, 64'd1);
      step();
    end
    chk("discard_addr", ireq_addr, 64'h8000_0010);
    data_ok = 1'b1;
    step();
    data_ok = 1'b0;
    chk("discard_no_out", {63'h0, out_valid}, 64'd0);
    chk("rd1_next_valid", {63'h0, ireq_valid}, 64'd1);
    chk("rd1_next_addr", ireq_addr, 64'h8000_0100);

    // Enter DISCARD, then two more redirects; the last one wins.
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_0700;
    step();
    redirect_pc    = 64'h8000_0100;
    step();
    redirect_pc    = 64'h8000_0200;
    step();
    redirect_valid = 1'b0;
    chk("rd2_stale_addr", ireq_addr, 64'h8000_0100);
    data_ok = 1'b1;
    step();
    data_ok = 1'b0;
    chk("rd2_no_out", {63'h0, out_valid}, 64'd0);
    chk("rd2_next_addr", ireq_addr, 64'h8000_0200);

    // Redirect in HOLD together with out_ready: the buffer is dropped.
    data_ok = 1'b1;
    data    = 32'h00A0_0093;
    push_exp(64'h8000_0200, 32'h00A0_0093, 1'b0);
    step();
    data_ok = 1'b0;
    expect_out();
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_0300;
    out_ready      = 1'b1;
    step();
    redirect_valid = 1'b0;
    out_ready      = 1'b0;
    chk("hold_rd_out_valid", {63'h0, out_valid}, 64'd0);
    chk("hold_rd_req_valid", {63'h0, ireq_valid}, 64'd1);
    chk("hold_rd_req_addr", ireq_addr, 64'h8000_0300);

    // Redirect with data_ok in REQ goes straight to a misaligned PC.
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_0102;
    data_ok        = 1'b1;
    step();
    redirect_valid = 1'b0;
    data_ok        = 1'b0;
    chk("mis_no_req", {63'h0, ireq_valid}, 64'd0);
    chk("mis_no_load", {63'h0, out_valid}, 64'd0);
    push_exp(64'h8000_0102, 32'h0, 1'b1);
    step();
    expect_out();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("mis2_no_req", {63'h0, ireq_valid}, 64'd0);
    push_exp(64'h8000_0106, 32'h0, 1'b1);
    step();
    expect_out();

    // Wrap-around at the top of the address space.
    redirect_valid = 1'b1;
    redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFC;
    step();
    redirect_valid = 1'b0;
    chk("wrap_req_valid", {63'h0, ireq_valid}, 64'd1);
    fetch_one('{lat: 0, inst: 32'h0000_0073, stall: 0, exp_pc: 64'hFFFF_FFFF_FFFF_FFFC});

    // Asynchronous reset while a stale request is outstanding.
    redirect_valid = 1'b1;
    redirect_pc    = 64'h0000_0040;
    step();
    redirect_valid = 1'b0;
    chk("pre_rst_valid", {63'h0, ireq_valid}, 64'd1);
    chk("pre_rst_addr", ireq_addr, 64'h0);
    #2;
    reset = 1'b0;
    #1;
    chk("async_rst_drop", {63'h0, ireq_valid}, 64'd0);
    chk("async_rst_out", {63'h0, out_valid}, 64'd0);
    step();
    step();
    chk("rst_held_no_req", {63'h0, ireq_valid}, 64'd0);
    reset = 1'b1;
    #1;
    chk("restart_valid", {63'h0, ireq_valid}, 64'd1);
    chk("restart_addr", ireq_addr, RstPc);
    fetch_one('{lat: 1, inst: 32'h0000_0513, stall: 2, exp_pc: RstPc});

    chk("scoreboard_drained", 64'(sb_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
